// File: rtl/mdu_execute_if.sv
// Shared types and the EX-stage <-> multiply/divide unit interface.
// The EX stage drives operands and control; the unit returns stall/busy/result.
package mdu_pkg;
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;
endpackage

interface mdu_execute_if #(
    parameter int XLEN = 32
);
    import mdu_pkg::*;

    logic            valid;
    logic            start;
    logic [2:0]      md_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] exmem_forwarded_data;
    logic [XLEN-1:0] memwb_forwarded_data;
    fwd_sel_e        forward_a;
    fwd_sel_e        forward_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output valid, start, md_op, rs1_data, rs2_data,
               exmem_forwarded_data, memwb_forwarded_data,
               forward_a, forward_b, flush,
        input  stall, busy, result_valid, result
    );

    modport slave (
        input  valid, start, md_op, rs1_data, rs2_data,
               exmem_forwarded_data, memwb_forwarded_data,
               forward_a, forward_b, flush,
        output stall, busy, result_valid, result
    );
endinterface

// File: rtl/mdu_execute.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage (radix-2 iteration).
// Define MDU_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module mdu_execute
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic         clk,
    input logic         rst,
    mdu_execute_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state, state_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [XLEN-1:0]   result_q;

    // Operand and iteration registers
    md_op_e            op_q;
    logic              neg_q, neg_rem_q, special_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] a_sh;
    logic [XLEN-1:0]   b_reg;

    function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_e sel,
                                                input logic [XLEN-1:0] id_val,
                                                input logic [XLEN-1:0] ex_val,
                                                input logic [XLEN-1:0] wb_val);
        case (sel)
            FWD_NONE:  return id_val;
            FWD_EXMEM: return ex_val;
            FWD_MEMWB: return wb_val;
            default:   return '1;
        endcase
    endfunction

    logic [XLEN-1:0] op_a, op_b, a_mag, b_mag;
    md_op_e          op_in;
    logic            is_div_in, a_signed_in, b_signed_in, sign_a_in, sign_b_in;
    logic            div_zero_in, div_ovf_in, mul_zero_in, skip_busy_in;
    logic            accept;

    assign op_a        = fwd_mux(bus.forward_a, bus.rs1_data, bus.exmem_forwarded_data, bus.memwb_forwarded_data);
    assign op_b        = fwd_mux(bus.forward_b, bus.rs2_data, bus.exmem_forwarded_data, bus.memwb_forwarded_data);
    assign op_in       = md_op_e'(bus.md_op);
    assign is_div_in   = bus.md_op[2];
    assign a_signed_in = op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign b_signed_in = op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    assign sign_a_in   = a_signed_in & op_a[XLEN-1];
    assign sign_b_in   = b_signed_in & op_b[XLEN-1];
    assign a_mag       = sign_a_in ? -op_a : op_a;
    assign b_mag       = sign_b_in ? -op_b : op_b;
    assign div_zero_in = is_div_in && (op_b == '0);
    assign div_ovf_in  = is_div_in && a_signed_in && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
`ifdef MDU_EARLY_OUT_EN
    assign mul_zero_in = !is_div_in && (b_mag == '0);
`else
    assign mul_zero_in = 1'b0;
`endif
    assign skip_busy_in = div_zero_in || div_ovf_in || mul_zero_in;
    assign accept       = (state == IDLE) && bus.valid && bus.start && !bus.flush;

    // One restoring-division step on {remainder, quotient} held in acc
    logic [XLEN:0]     r_shift, r_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    assign r_shift  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign r_diff   = r_shift - {1'b0, b_reg};
    assign div_ge   = r_shift >= {1'b0, b_reg};
    assign div_next = {div_ge ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0], acc[XLEN-2:0], div_ge};

    logic last_step;
`ifdef MDU_EARLY_OUT_EN
    assign last_step = (count == CNT_W'(1)) || (!op_q[2] && (b_reg[XLEN-1:1] == '0));
`else
    assign last_step = (count == CNT_W'(1));
`endif

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_next       = state;
        count_next       = count;
        bus.stall        = 1'b0;
        bus.result_valid = 1'b0;
        if (bus.flush) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state_next = skip_busy_in ? DONE : BUSY;
                    count_next = skip_busy_in ? '0 : CNT_W'(XLEN);
                end
                BUSY: begin
                    count_next = count - CNT_W'(1);
                    if (last_step) state_next = DONE;
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
            bus.stall        = accept || (state == BUSY);
            bus.result_valid = (state == DONE);
        end
    end

    assign bus.busy = (state != IDLE);

    // Sign correction and result selection, meaningful only in DONE
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, final_res;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quot = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                        final_res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               final_res = (special_q || !neg_q) ? quot : -quot;
            default:                       final_res = (special_q || !neg_rem_q) ? rem : -rem;
        endcase
    end

    assign bus.result = (state == DONE) ? final_res : result_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (bus.result_valid) result_q <= final_res;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= op_in;
            neg_q     <= sign_a_in ^ sign_b_in;
            neg_rem_q <= sign_a_in;
            special_q <= div_zero_in || div_ovf_in;
            b_reg     <= b_mag;
            a_sh      <= {{XLEN{1'b0}}, a_mag};
            if (div_zero_in)     acc <= {op_a, {XLEN{1'b1}}};
            else if (div_ovf_in) acc <= {{XLEN{1'b0}}, op_a};
            else if (is_div_in)  acc <= {{XLEN{1'b0}}, a_mag};
            else                 acc <= '0;
        end else if (state == BUSY) begin
            if (op_q[2]) begin
                acc <= div_next;
            end else begin
                if (b_reg[0]) acc <= acc + a_sh;
                a_sh  <= a_sh << 1;
                b_reg <= b_reg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_execute.sv
// Directed self-checking bench for mdu_execute at XLEN=32.
// Expected latencies follow MDU_EARLY_OUT_EN when the bench is built with it.
module tb_mdu_execute;
    import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    mdu_execute_if #(.XLEN(32)) bus ();

    mdu_execute #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int mul_lat(input logic [31:0] bmag);
        int hi = 0;
        if (!EARLY) return 33;
        if (bmag == 0) return 1;
        for (int i = 0; i < 32; i++) if (bmag[i]) hi = i;
        return hi + 2;
    endfunction

    task automatic expect_bit(input string name, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input fwd_sel_e fa, input fwd_sel_e fb, input bit chk_stall, input string name);
        bus.valid     = 1'b1;
        bus.start     = 1'b1;
        bus.md_op     = op;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.forward_a = fa;
        bus.forward_b = fb;
        if (chk_stall) begin
            #1;
            expect_bit({name, " stall on accept"}, bus.stall, 1'b1);
        end
    endtask

    // Called at a negedge; waits edge by edge for result_valid and checks latency and value.
    task automatic wait_result(input string name, input int lat, input logic [31:0] exp, input int done_edges);
        int n = done_edges;
        bit seen = 0;
        int stall_gap = 0;
        while (n < 80 && !seen) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.result_valid) seen = 1;
            else if (!bus.stall) stall_gap++;
        end
        tests_run++;
        if (!seen || n != lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, n, seen, lat);
        end
        if (seen) begin
            tests_run++;
            if (bus.result !== exp) begin
                tests_failed++;
                $display("FAIL %s result: got %h expected %h", name, bus.result, exp);
            end
            tests_run++;
            if (bus.stall !== 1'b0 || stall_gap != 0) begin
                tests_failed++;
                $display("FAIL %s stall: done-cycle stall %b, early drops %0d, expected 0 and 0", name, bus.stall, stall_gap);
            end
        end
        bus.valid = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_bit("reset stall", bus.stall, 1'b0);
        expect_bit("reset busy", bus.busy, 1'b0);
        expect_bit("reset result_valid", bus.result_valid, 1'b0);
        tests_run++;
        if (bus.result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset result: got %h expected 00000000", bus.result);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, FWD_NONE, FWD_NONE, 1, "mul 7*-3");
        wait_result("mul 7*-3", mul_lat(32'd3), 32'hFFFF_FFEB, 0);
        @(negedge clk);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, FWD_NONE, FWD_NONE, 1, "mulh -2*3");
        wait_result("mulh -2*3", mul_lat(32'd3), 32'hFFFF_FFFF, 0);
        @(negedge clk);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FWD_NONE, FWD_NONE, 1, "mulhsu -1*max");
        wait_result("mulhsu -1*max", mul_lat(32'hFFFF_FFFF), 32'hFFFF_FFFF, 0);
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd5, FWD_NONE, FWD_NONE, 1, "mul 3*5");
        wait_result("mul 3*5", EARLY ? 4 : 33, 32'd15, 0);
        @(negedge clk);
        issue(3'd0, 32'd9, 32'd0, FWD_NONE, FWD_NONE, 1, "mul 9*0");
        wait_result("mul 9*0", EARLY ? 1 : 33, 32'd0, 0);
        @(negedge clk);
    endtask

    task automatic test_mulhu_fwd;
        bus.exmem_forwarded_data = 32'hFFFF_FFFF;
        issue(3'd3, 32'd0, 32'hFFFF_FFFF, FWD_EXMEM, FWD_NONE, 1, "mulhu fwd");
        @(posedge clk);
        @(negedge clk);
        bus.exmem_forwarded_data = 32'h1234_5678;
        wait_result("mulhu fwd", 33, 32'hFFFF_FFFE, 1);
        @(negedge clk);
    endtask

    task automatic test_fwd_sel;
        bus.memwb_forwarded_data = 32'd6;
        bus.exmem_forwarded_data = 32'd7;
        issue(3'd0, 32'd100, 32'd100, FWD_MEMWB, FWD_EXMEM, 1, "fwd memwb*exmem");
        wait_result("fwd memwb*exmem", mul_lat(32'd7), 32'd42, 0);
        @(negedge clk);
        issue(3'd0, 32'd100, 32'd2, fwd_sel_e'(2'd3), FWD_NONE, 1, "fwd invalid sel");
        wait_result("fwd invalid sel", mul_lat(32'd2), 32'hFFFF_FFFE, 0);
        @(negedge clk);
    endtask

    task automatic test_div_special;
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, FWD_NONE, FWD_NONE, 1, "div overflow");
        wait_result("div overflow", 1, 32'h8000_0000, 0);
        @(negedge clk);
        issue(3'd6, 32'd5, 32'd0, FWD_NONE, FWD_NONE, 1, "rem by zero");
        wait_result("rem by zero", 1, 32'd5, 0);
        @(negedge clk);
        issue(3'd5, 32'd5, 32'd0, FWD_NONE, FWD_NONE, 1, "divu by zero");
        wait_result("divu by zero", 1, 32'hFFFF_FFFF, 0);
        @(negedge clk);
    endtask

    task automatic test_signed_div;
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, FWD_NONE, FWD_NONE, 1, "rem -7/2");
        wait_result("rem -7/2", DIV_LAT, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, FWD_NONE, FWD_NONE, 1, "div -7/2");
        wait_result("div -7/2", DIV_LAT, 32'hFFFF_FFFD, 0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        issue(3'd5, 32'd100, 32'd7, FWD_NONE, FWD_NONE, 1, "b2b divu");
        wait_result("b2b divu", DIV_LAT, 32'd14, 0);
        // Second op presented during DONE; accepted in the following IDLE cycle
        issue(3'd7, 32'd100, 32'd7, FWD_NONE, FWD_NONE, 0, "b2b remu");
        wait_result("b2b remu", DIV_LAT + 1, 32'd2, 0);
        @(negedge clk);
    endtask

    task automatic test_flush;
        bit leaked = 0;
        issue(3'd5, 32'd1000, 32'd3, FWD_NONE, FWD_NONE, 1, "flush divu");
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        expect_bit("flush busy before", bus.busy, 1'b1);
        bus.flush = 1'b1;
        #1;
        expect_bit("flush stall same cycle", bus.stall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        expect_bit("flush idle next", bus.busy, 1'b0);
        expect_bit("flush beats start", bus.stall, 1'b0);
        expect_bit("flush no result_valid", bus.result_valid, 1'b0);
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        bus.start = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.result_valid) leaked = 1;
        end
        expect_bit("flush no late result", leaked, 1'b0);
    endtask

    task automatic test_reset_mid;
        bit leaked = 0;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, FWD_NONE, FWD_NONE, 1, "reset mid-op");
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.valid = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        expect_bit("mid reset stall", bus.stall, 1'b0);
        expect_bit("mid reset busy", bus.busy, 1'b0);
        expect_bit("mid reset result_valid", bus.result_valid, 1'b0);
        tests_run++;
        if (bus.result !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid reset result: got %h expected 00000000", bus.result);
        end
        rst = 1'b1;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.result_valid) leaked = 1;
        end
        expect_bit("mid reset no late result", leaked, 1'b0);
    endtask

    initial begin
        bus.valid                = 1'b0;
        bus.start                = 1'b0;
        bus.md_op                = 3'd0;
        bus.rs1_data             = '0;
        bus.rs2_data             = '0;
        bus.exmem_forwarded_data = '0;
        bus.memwb_forwarded_data = '0;
        bus.forward_a            = FWD_NONE;
        bus.forward_b            = FWD_NONE;
        bus.flush                = 1'b0;

        test_reset();
        test_mul();
        test_mulhu_fwd();
        test_fwd_sel();
        test_div_special();
        test_signed_div();
        test_back_to_back();
        test_flush();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
